// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: pulls bytes from a TX FIFO and serialises them as UART frames.
// Frame: start bit, 8 data bits LSB first, optional parity bit, one or two stop bits.
// Baud timing, parity mode and stop-bit count are captured when a byte is fetched, so
// changing the inputs during a frame only affects later frames.
//
// Handshake with the TX FIFO: fifoData is valid whenever fifoEmpty=0. fifoRe is a one-cycle
// pop strobe. It is asserted only in a cycle where fifoEmpty=0 and txEnable=1, and only
// while the sequencer is idle or in the last cycle of the final stop bit. The byte is
// consumed on the rising edge that ends that cycle.
module uart_tx_sequencer #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 txEnable,
    input  logic [DIV_WIDTH-1:0] baudDivisor,
    input  logic                 parityEnable,
    input  logic                 parityOdd,
    input  logic                 twoStopBits,
    input  logic                 fifoEmpty,
    input  logic [7:0]           fifoData,
    output logic                 fifoRe,
    output logic                 txd,
    output logic                 busy,
    output logic                 frameDone
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } stateT;

    stateT                state,        stateNext;
    logic [DIV_WIDTH-1:0] bitTimer,     bitTimerNext;
    logic [DIV_WIDTH-1:0] divLatch,     divLatchNext;
    logic [2:0]           bitIndex,     bitIndexNext;
    logic [7:0]           shiftReg,     shiftRegNext;
    logic                 parityBit,    parityBitNext;
    logic                 parityOn,     parityOnNext;
    logic                 twoStop,      twoStopNext;
    logic                 stopIndex,    stopIndexNext;
    logic                 txdReg,       txdNext;
    logic                 bitDone;
    logic                 lastStopCycle;
    logic                 fetch;

    // Frame sequencing: next-state, timer, shift and latched-configuration logic
    always_comb begin
        stateNext     = state;
        bitTimerNext  = bitTimer;
        divLatchNext  = divLatch;
        bitIndexNext  = bitIndex;
        shiftRegNext  = shiftReg;
        parityBitNext = parityBit;
        parityOnNext  = parityOn;
        twoStopNext   = twoStop;
        stopIndexNext = stopIndex;
        txdNext       = 1'b1;

        bitDone       = (bitTimer == '0);
        lastStopCycle = (state == STOP) && bitDone && (!twoStop || stopIndex);
        fetch         = txEnable && !fifoEmpty && ((state == IDLE) || lastStopCycle);

        if (!bitDone) begin
            bitTimerNext = bitTimer - 1'b1;
        end

        case (state)
            IDLE: begin
                stateNext = IDLE;
            end
            START: begin
                if (bitDone) begin
                    stateNext    = DATA;
                    bitTimerNext = divLatch;
                    bitIndexNext = 3'd0;
                end
            end
            DATA: begin
                if (bitDone) begin
                    bitTimerNext = divLatch;
                    if (bitIndex == 3'd7) begin
                        stateNext     = parityOn ? PARITY : STOP;
                        stopIndexNext = 1'b0;
                    end else begin
                        bitIndexNext = bitIndex + 3'd1;
                        shiftRegNext = {1'b0, shiftReg[7:1]};
                    end
                end
            end
            PARITY: begin
                if (bitDone) begin
                    stateNext     = STOP;
                    bitTimerNext  = divLatch;
                    stopIndexNext = 1'b0;
                end
            end
            STOP: begin
                if (bitDone) begin
                    if (lastStopCycle) begin
                        stateNext = IDLE;
                    end else begin
                        stopIndexNext = 1'b1;
                        bitTimerNext  = divLatch;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        // A fetch overrides the above: from IDLE or straight out of the last stop cycle.
        if (fetch) begin
            stateNext     = START;
            bitTimerNext  = baudDivisor;
            divLatchNext  = baudDivisor;
            shiftRegNext  = fifoData;
            parityBitNext = (^fifoData) ^ parityOdd;
            parityOnNext  = parityEnable;
            twoStopNext   = twoStopBits;
            bitIndexNext  = 3'd0;
            stopIndexNext = 1'b0;
        end

        // txd is registered, so it is computed from the state being entered.
        case (stateNext)
            START:   txdNext = 1'b0;
            DATA:    txdNext = shiftRegNext[0];
            PARITY:  txdNext = parityBitNext;
            default: txdNext = 1'b1;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bitTimer  <= '0;
            divLatch  <= '0;
            bitIndex  <= 3'd0;
            shiftReg  <= 8'h00;
            parityBit <= 1'b0;
            parityOn  <= 1'b0;
            twoStop   <= 1'b0;
            stopIndex <= 1'b0;
            txdReg    <= 1'b1;
        end else begin
            state     <= stateNext;
            bitTimer  <= bitTimerNext;
            divLatch  <= divLatchNext;
            bitIndex  <= bitIndexNext;
            shiftReg  <= shiftRegNext;
            parityBit <= parityBitNext;
            parityOn  <= parityOnNext;
            twoStop   <= twoStopNext;
            stopIndex <= stopIndexNext;
            txdReg    <= txdNext;
        end
    end

    // The pop strobe is gated by reset so the FIFO is never popped while held in reset.
    assign fifoRe    = fetch && reset;
    assign frameDone = lastStopCycle;
    assign busy      = (state != IDLE);
    assign txd       = txdReg;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed testbench for uart_tx_sequencer: single byte, parity modes, back-to-back,
// mid-frame input changes and mid-frame reset. The TX FIFO is modelled by a queue.
module tb_uart_tx_sequencer;

    localparam int DW = 16;
    localparam int LOG_SIZE = 16384;

    logic          clock = 1'b0;
    logic          reset;
    logic          txEnable;
    logic [DW-1:0] baudDivisor;
    logic          parityEnable;
    logic          parityOdd;
    logic          twoStopBits;
    logic          fifoEmpty;
    logic [7:0]    fifoData;
    logic          fifoRe;
    logic          txd;
    logic          busy;
    logic          frameDone;

    int         checkCount = 0;
    int         failCount = 0;
    logic [7:0] fifoQ[$];
    logic       txdLog[0:LOG_SIZE-1];
    logic       busyLog[0:LOG_SIZE-1];
    int         negIdx = 0;
    int         reLog[$];
    int         doneLog[$];
    bit         popPending = 1'b0;

    uart_tx_sequencer #(.DIV_WIDTH(DW)) dut (
        .clock(clock),
        .reset(reset),
        .txEnable(txEnable),
        .baudDivisor(baudDivisor),
        .parityEnable(parityEnable),
        .parityOdd(parityOdd),
        .twoStopBits(twoStopBits),
        .fifoEmpty(fifoEmpty),
        .fifoData(fifoData),
        .fifoRe(fifoRe),
        .txd(txd),
        .busy(busy),
        .frameDone(frameDone)
    );

    // Clock
    always #5 clock = ~clock;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void updatePins();
        fifoEmpty = (fifoQ.size() == 0);
        fifoData  = (fifoQ.size() == 0) ? 8'h00 : fifoQ[0];
    endfunction

    task automatic pushByte(input logic [7:0] b);
        fifoQ.push_back(b);
        updatePins();
    endtask

    // Monitor: sample outputs mid-cycle on the falling edge
    always @(negedge clock) begin
        if (negIdx < LOG_SIZE - 1) negIdx = negIdx + 1;
        txdLog[negIdx]  = txd;
        busyLog[negIdx] = busy;
        if (fifoRe === 1'b1) begin
            reLog.push_back(negIdx);
            popPending = 1'b1;
            checkValue("re_while_empty", {31'd0, fifoEmpty}, 32'd0);
        end
        if (frameDone === 1'b1) doneLog.push_back(negIdx);
    end

    // FIFO model: a strobe seen mid-cycle pops the head just after the consuming edge
    always @(posedge clock) begin
        #1;
        if (popPending) begin
            popPending = 1'b0;
            if (fifoQ.size() > 0) void'(fifoQ.pop_front());
            updatePins();
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic waitUntil(input int idx);
        while (negIdx < idx) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic waitFetch(input string tag, input int prev, input int maxCycles, output int f);
        for (int i = 0; i < maxCycles; i++) begin
            if (reLog.size() > prev) break;
            @(negedge clock);
            #1;
        end
        if (reLog.size() > prev) begin
            f = reLog[prev];
        end else begin
            checkValue({tag, "_fetch_timeout"}, 32'd0, 32'd1);
            f = negIdx;
        end
    endtask

    // Checks a whole frame whose fetch strobe was seen at sample index f.
    task automatic checkFrame(input string tag, input int f, input int d, input logic [7:0] data,
                              input bit pe, input bit par, input bit ts);
        int   nb;
        int   good;
        int   endIdx;
        int   early;
        bit   found;
        logic exp;
        nb = 10 + int'(pe) + int'(ts);
        for (int b = 0; b < nb; b++) begin
            if (b == 0) exp = 1'b0;
            else if (b <= 8) exp = data[b-1];
            else if (b == 9 && pe) exp = par;
            else exp = 1'b1;
            good = 0;
            for (int j = 0; j < d + 1; j++) begin
                if (txdLog[f + 1 + b * (d + 1) + j] === exp) good++;
            end
            checkValue($sformatf("%s_bit%0d", tag, b), good, d + 1);
        end
        endIdx = f + nb * (d + 1);
        found = 1'b0;
        early = 0;
        foreach (doneLog[k]) begin
            if (doneLog[k] == endIdx) found = 1'b1;
            if (doneLog[k] > f && doneLog[k] < endIdx) early++;
        end
        checkValue({tag, "_done_at_end"}, {31'd0, found}, 32'd1);
        checkValue({tag, "_done_early"}, early, 32'd0);
        checkValue({tag, "_busy_last"}, {31'd0, busyLog[endIdx]}, 32'd1);
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         f;
        int         f2;
        int         expF2;
        int         prev;
        int         doneBefore;
        int         reBefore;
        int         cnt;
        logic [9:0] a5Obs;
        logic [9:0] a5Pattern;

        a5Pattern    = 10'b11_0100_1010;
        reset        = 1'b0;
        txEnable     = 1'b0;
        baudDivisor  = '0;
        parityEnable = 1'b0;
        parityOdd    = 1'b0;
        twoStopBits  = 1'b0;
        updatePins();
        repeat (2) tick();
        reset = 1'b1;
        repeat (3) tick();

        // Reset asserted between clock edges takes effect with no edge
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        checkValue("rst_txd", {31'd0, txd}, 32'd1);
        checkValue("rst_busy", {31'd0, busy}, 32'd0);
        checkValue("rst_fifore", {31'd0, fifoRe}, 32'd0);
        checkValue("rst_done", {31'd0, frameDone}, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Single byte 0xA5, D=3, no parity, one stop bit
        baudDivisor = 16'd3;
        txEnable    = 1'b1;
        prev        = reLog.size();
        doneBefore  = doneLog.size();
        pushByte(8'hA5);
        waitFetch("a5", prev, 10, f);
        waitUntil(f + 45);
        for (int k = 0; k < 10; k++) a5Obs[k] = txdLog[f + 1 + 4 * k];
        checkValue("a5_pattern", {22'd0, a5Obs}, {22'd0, a5Pattern});
        checkValue("a5_pops", reLog.size() - prev, 32'd1);
        checkValue("a5_done_count", doneLog.size() - doneBefore, 32'd1);
        checkValue("a5_busy_after", {31'd0, busyLog[f + 41]}, 32'd0);
        checkFrame("a5", f, 3, 8'hA5, 1'b0, 1'b0, 1'b0);

        // Parity: 0x07, D=0, even parity -> parity bit 1, 11-cycle frame
        tick();
        baudDivisor  = 16'd0;
        parityEnable = 1'b1;
        parityOdd    = 1'b0;
        prev         = reLog.size();
        pushByte(8'h07);
        waitFetch("par_even", prev, 10, f);
        waitUntil(f + 15);
        checkValue("par_even_bit", {31'd0, txdLog[f + 10]}, 32'd1);
        checkValue("par_even_len", doneLog[doneLog.size() - 1] - f, 32'd11);
        checkFrame("par_even", f, 0, 8'h07, 1'b1, 1'b1, 1'b0);

        // Odd parity -> parity bit 0
        tick();
        parityOdd = 1'b1;
        prev      = reLog.size();
        pushByte(8'h07);
        waitFetch("par_odd", prev, 10, f);
        waitUntil(f + 15);
        checkValue("par_odd_bit", {31'd0, txdLog[f + 10]}, 32'd0);
        checkFrame("par_odd", f, 0, 8'h07, 1'b1, 1'b0, 1'b0);

        // Even parity with two stop bits -> 12-cycle frame
        tick();
        parityOdd   = 1'b0;
        twoStopBits = 1'b1;
        prev        = reLog.size();
        pushByte(8'h07);
        waitFetch("two_stop", prev, 10, f);
        waitUntil(f + 16);
        checkValue("two_stop_len", doneLog[doneLog.size() - 1] - f, 32'd12);
        checkFrame("two_stop", f, 0, 8'h07, 1'b1, 1'b1, 1'b1);

        // Back-to-back: three bytes, D=0, no parity
        tick();
        parityEnable = 1'b0;
        twoStopBits  = 1'b0;
        prev         = reLog.size();
        doneBefore   = doneLog.size();
        pushByte(8'h3C);
        pushByte(8'h81);
        pushByte(8'h5A);
        waitFetch("b2b", prev, 10, f);
        waitUntil(f + 36);
        checkValue("b2b_pops", reLog.size() - prev, 32'd3);
        if (reLog.size() - prev == 3) begin
            checkValue("b2b_gap1", reLog[prev + 1] - reLog[prev], 32'd10);
            checkValue("b2b_gap2", reLog[prev + 2] - reLog[prev + 1], 32'd10);
        end
        cnt = 0;
        for (int k = f + 1; k <= f + 30; k++) if (busyLog[k] === 1'b1) cnt++;
        checkValue("b2b_no_idle", cnt, 32'd30);
        checkValue("b2b_done_count", doneLog.size() - doneBefore, 32'd3);
        checkFrame("b2b0", f, 0, 8'h3C, 1'b0, 1'b0, 1'b0);
        checkFrame("b2b1", f + 10, 0, 8'h81, 1'b0, 1'b0, 1'b0);
        checkFrame("b2b2", f + 20, 0, 8'h5A, 1'b0, 1'b0, 1'b0);
        checkValue("b2b_busy_end", {31'd0, busyLog[f + 31]}, 32'd0);
        checkValue("b2b_fifo_empty", {31'd0, fifoEmpty}, 32'd1);

        // Divisor changed 3 -> 7 during DATA: old frame keeps 4-cycle bits
        tick();
        baudDivisor = 16'd3;
        prev        = reLog.size();
        pushByte(8'h11);
        pushByte(8'h22);
        waitFetch("div", prev, 10, f);
        waitUntil(f + 10);
        baudDivisor = 16'd7;
        waitUntil(f + 40 + 80 + 4);
        checkValue("div_pops", reLog.size() - prev, 32'd2);
        if (reLog.size() - prev == 2) checkValue("div_second_fetch", reLog[prev + 1] - f, 32'd40);
        checkFrame("div_old", f, 3, 8'h11, 1'b0, 1'b0, 1'b0);
        checkFrame("div_new", f + 40, 7, 8'h22, 1'b0, 1'b0, 1'b0);

        // txEnable dropped during DATA: frame completes, no further fetch
        tick();
        baudDivisor = 16'd1;
        prev        = reLog.size();
        pushByte(8'h33);
        pushByte(8'h44);
        waitFetch("ten", prev, 10, f);
        waitUntil(f + 8);
        txEnable = 1'b0;
        waitUntil(f + 20 + 10);
        checkFrame("ten_drop", f, 1, 8'h33, 1'b0, 1'b0, 1'b0);
        checkValue("ten_pops", reLog.size() - prev, 32'd1);
        checkValue("ten_idle", {31'd0, busyLog[f + 21]}, 32'd0);
        fifoQ.delete();
        updatePins();
        tick();
        txEnable = 1'b1;

        // Reset during data bit 4 of 0xE5, second byte waiting
        baudDivisor = 16'd3;
        prev        = reLog.size();
        pushByte(8'hE5);
        pushByte(8'h5A);
        waitFetch("rst_mid", prev, 10, f);
        doneBefore = doneLog.size();
        waitUntil(f + 22);
        checkValue("rst_mid_bit4", {31'd0, txdLog[f + 22]}, 32'd0);
        reset = 1'b0;
        #1;
        checkValue("rst_mid_txd", {31'd0, txd}, 32'd1);
        checkValue("rst_mid_busy", {31'd0, busy}, 32'd0);
        checkValue("rst_mid_done", {31'd0, frameDone}, 32'd0);
        checkValue("rst_mid_fifore", {31'd0, fifoRe}, 32'd0);
        reBefore = reLog.size();
        tick();
        tick();
        checkValue("rst_mid_no_fetch", reLog.size() - reBefore, 32'd0);
        reset = 1'b1;
        expF2 = negIdx + 1;
        waitFetch("rst_release", reBefore, 10, f2);
        checkValue("rst_release_fetch", f2, expF2);
        waitUntil(f2 + 45);
        checkFrame("after_rst", f2, 3, 8'h5A, 1'b0, 1'b0, 1'b0);
        checkValue("rst_mid_done_count", doneLog.size() - doneBefore, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
